// File: rtl/sr_flag_bank.sv
// Purpose : bank of N set/reset status flags with per-channel reset value,
//           set/clear priority and optional rising-edge set qualifier, plus
//           pending latches, an interrupt mask and one registered interrupt.
// Latency : q and pend update on the edge sampling the request; irq follows
//           pend/mask one cycle later.
// Backpressure: none, every request is consumed on the sampling edge.
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-low reset
//   set_in    per-channel set request
//   clr_in    per-channel clear request
//   pend_clr  write-1-to-clear for pending bits
//   mask_we   load mask register from mask_din
//   mask_din  new interrupt mask value (1 = enabled)
//   q         flag state
//   pend      pending bits (flag rose 0->1)
//   mask      current interrupt mask
//   irq       OR of enabled pending bits, registered

module sr_flag_bank #(
    parameter int             N            = 4,
    parameter logic [N-1:0]   RESET_VAL    = {N{1'b0}},
    parameter logic [N-1:0]   SET_PRIORITY = {N{1'b1}},
    parameter logic [N-1:0]   EDGE_MODE    = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] set_in,
    input  logic [N-1:0] clr_in,
    input  logic [N-1:0] pend_clr,
    input  logic         mask_we,
    input  logic [N-1:0] mask_din,
    output logic [N-1:0] q,
    output logic [N-1:0] pend,
    output logic [N-1:0] mask,
    output logic         irq
);

    logic [N-1:0] flag_q, flag_d;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] mask_q, mask_d;
    logic         irq_q,  irq_d;
    logic [N-1:0] set_dly_q;
    logic [N-1:0] set_eff;
    logic [N-1:0] rise;

    // Edge-mode channels only see a set when set_in was low last cycle.
    // set_dly_q resets to 0, so a set held through reset release counts once.
    assign set_eff = set_in & ~(EDGE_MODE & set_dly_q);

    always_comb begin
        flag_d = (set_eff & ~clr_in)
               | (set_eff &  clr_in & SET_PRIORITY)
               | (~set_eff & ~clr_in & flag_q);
        rise   = flag_d & ~flag_q;
        // A rise in the same cycle as pend_clr keeps the bit set.
        pend_d = rise | (pend_q & ~pend_clr);
        mask_d = mask_we ? mask_din : mask_q;
        // Uses registered pend/mask, so irq lags them by one cycle.
        irq_d  = |(pend_q & mask_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q    <= RESET_VAL;
            pend_q    <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            set_dly_q <= '0;
        end else begin
            flag_q    <= flag_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            set_dly_q <= set_in;
        end
    end

    assign q    = flag_q;
    assign pend = pend_q;
    assign mask = mask_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
module tb_sr_flag_bank;

    localparam int           N    = 4;
    localparam logic [N-1:0] RV   = 4'b0001;
    localparam logic [N-1:0] PRIO = 4'b0011;
    localparam logic [N-1:0] EDGE = 4'b0100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] set_in = '0, clr_in = '0, pend_clr = '0, mask_din = '0;
    logic         mask_we = 1'b0;
    logic [N-1:0] q, pend, mask;
    logic         irq;

    int checks = 0;
    int failures = 0;

    // reference state
    bit [N-1:0] m_q, m_pend, m_mask, m_setd;
    bit         m_irq;

    sr_flag_bank #(.N(N), .RESET_VAL(RV), .SET_PRIORITY(PRIO), .EDGE_MODE(EDGE)) dut (
        .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in), .pend_clr(pend_clr),
        .mask_we(mask_we), .mask_din(mask_din), .q(q), .pend(pend), .mask(mask), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = RV; m_pend = '0; m_mask = '0; m_irq = 1'b0; m_setd = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    32'(q),    32'(m_q));
        chk({tag, ".pend"}, 32'(pend), 32'(m_pend));
        chk({tag, ".mask"}, 32'(mask), 32'(m_mask));
        chk({tag, ".irq"},  32'(irq),  32'(m_irq));
    endtask

    // One clock: model next state from the rules, advance DUT, compare.
    task automatic cycle(input string tag);
        bit [N-1:0] nq, np, nm;
        bit         ni, se;
        for (int i = 0; i < N; i++) begin
            se = EDGE[i] ? (set_in[i] && !m_setd[i]) : set_in[i];
            if (se && clr_in[i])  nq[i] = PRIO[i];
            else if (se)          nq[i] = 1'b1;
            else if (clr_in[i])   nq[i] = 1'b0;
            else                  nq[i] = m_q[i];
            if (nq[i] && !m_q[i]) np[i] = 1'b1;
            else if (pend_clr[i]) np[i] = 1'b0;
            else                  np[i] = m_pend[i];
        end
        nm = mask_we ? mask_din : m_mask;
        ni = (m_pend & m_mask) != 0;
        @(posedge clk);
        #1;
        m_q = nq; m_pend = np; m_mask = nm; m_irq = ni; m_setd = set_in;
        check_all(tag);
    endtask

    task automatic drive(input logic [N-1:0] s, input logic [N-1:0] c,
                         input logic [N-1:0] pc, input logic we, input logic [N-1:0] md);
        set_in = s; clr_in = c; pend_clr = pc; mask_we = we; mask_din = md;
    endtask

    task automatic idle();
        drive('0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        // 1: asynchronous reset between edges, then idle
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst.q", 32'(q), 32'(4'b0001));
        chk("rst.pend", 32'(pend), 32'(4'b0000));
        chk("rst.mask", 32'(mask), 32'(4'b0000));
        chk("rst.irq", 32'(irq), 32'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) cycle("idle");
        chk("idle.q", 32'(q), 32'(4'b0001));

        // 2: simultaneous set and clear on every channel
        drive(4'b1111, 4'b1111, '0, 1'b0, '0);
        cycle("simul");
        chk("simul.q", 32'(q), 32'(4'b0011));
        chk("simul.pend", 32'(pend), 32'(4'b0010));
        idle();
        cycle("simul_idle");

        // 3: edge-mode channel 2
        drive(4'b0100, '0, '0, 1'b0, '0);
        cycle("edge_rise");
        chk("edge_rise.q2", 32'(q[2]), 32'(1'b1));
        drive(4'b0100, 4'b0100, '0, 1'b0, '0);
        cycle("edge_clr");
        chk("edge_clr.q2", 32'(q[2]), 32'(1'b0));
        drive(4'b0100, '0, '0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            cycle("edge_hold");
            chk("edge_hold.q2", 32'(q[2]), 32'(1'b0));
        end
        idle();
        cycle("edge_drop");
        drive(4'b0100, '0, '0, 1'b0, '0);
        cycle("edge_reraise");
        chk("edge_reraise.q2", 32'(q[2]), 32'(1'b1));

        // 4: interrupt path on channel 1
        drive('0, 4'b0010, 4'b1111, 1'b1, 4'b0010);
        cycle("irq_prep");
        chk("irq_prep.pend", 32'(pend), 32'(4'b0000));
        drive(4'b0010, '0, '0, 1'b0, '0);
        cycle("irq_set");
        chk("irq_set.pend1", 32'(pend[1]), 32'(1'b1));
        chk("irq_set.irq", 32'(irq), 32'(1'b0));
        idle();
        cycle("irq_on");
        chk("irq_on.irq", 32'(irq), 32'(1'b1));
        drive('0, '0, 4'b0010, 1'b0, '0);
        cycle("irq_pclr");
        chk("irq_pclr.pend1", 32'(pend[1]), 32'(1'b0));
        chk("irq_pclr.irq", 32'(irq), 32'(1'b1));
        idle();
        cycle("irq_off");
        chk("irq_off.irq", 32'(irq), 32'(1'b0));

        // 5: rise beats pend_clr on channel 3
        drive(4'b1000, '0, '0, 1'b0, '0);
        cycle("col_set");
        drive('0, 4'b1000, '0, 1'b0, '0);
        cycle("col_clr");
        chk("col_clr.q3", 32'(q[3]), 32'(1'b0));
        chk("col_clr.pend3", 32'(pend[3]), 32'(1'b1));
        drive(4'b1000, '0, 4'b1000, 1'b0, '0);
        cycle("col_hit");
        chk("col_hit.pend3", 32'(pend[3]), 32'(1'b1));
        drive('0, '0, 4'b1000, 1'b0, '0);
        cycle("col_pclr");
        chk("col_pclr.pend3", 32'(pend[3]), 32'(1'b0));

        // 6: reset mid-operation
        drive('0, 4'b1110, 4'b1111, 1'b0, '0);
        cycle("mid_prep");
        drive(4'b1111, '0, '0, 1'b1, 4'b1111);
        cycle("mid_set");
        idle();
        cycle("mid_irq");
        chk("mid.q", 32'(q), 32'(4'b1111));
        chk("mid.pend", 32'(pend), 32'(4'b1110));
        chk("mid.irq", 32'(irq), 32'(1'b1));
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("midrst.q", 32'(q), 32'(4'b0001));
        chk("midrst.pend", 32'(pend), 32'(4'b0000));
        chk("midrst.mask", 32'(mask), 32'(4'b0000));
        chk("midrst.irq", 32'(irq), 32'(1'b0));
        @(negedge clk);
        rst = 1'b1;

        // random traffic against the reference, with occasional async resets
        for (int k = 0; k < 400; k++) begin
            drive(4'($urandom), 4'($urandom & $urandom), 4'($urandom & $urandom),
                  1'($urandom_range(0, 7) == 0), 4'($urandom));
            cycle("rand");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                model_reset();
                check_all("rand_rst");
                rst = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
